dct_mac_sequencer: RTL and testbench
====================================

Name: dct_mac_sequencer

Overview:
- Sequences one DCT MAC unit inside a `dct_block`: per input row it issues TAPS multiply-accumulate steps, waits out the multiplier pipeline, then strobes the accumulated coefficient out.
- Tracks row index 0..ROWS-1 and flags 8x8 block completion.
- Sits between the fdct input row buffer / coefficient ROM and the `macu` (`mult_res` register + accumulator).
- Queues one pending start request and flags overrun.

Parameters:
- TAPS, 8, MAC steps per coefficient (power of 2, >=2)
- MULT_LAT, 2, cycles from mac_en asserted to product present at accumulator input (>=1)
- ROWS, 8, rows per block (power of 2)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous active-low reset
- ena  in  1  global clock enable; when 0 all state holds and every strobe output is forced to 0
- dstrb  in  1  row start request, 1-cycle pulse, sampled only when ena=1
- tap_sel  out  log2(TAPS)  sample/coefficient ROM index for the current MAC step
- mac_en  out  1  load `mult_res` this cycle (valid tap issued)
- acc_clr  out  1  clear accumulator before the first product of a row
- acc_en  out  1  accumulate the product emerging from the multiplier pipe
- res_strb  out  1  1-cycle pulse: accumulator holds the final coefficient
- row_idx  out  log2(ROWS)  row of the current/last result
- blk_done  out  1  1-cycle pulse coincident with res_strb of row ROWS-1
- busy  out  1  state != IDLE
- overrun  out  1  sticky; set when dstrb arrives while busy and a request is already pending

Behaviour:
- Reset values: all outputs 0; state IDLE; pending=0.
- Reset asserted mid-row aborts immediately: outputs return to reset values, and the row is not completed.
- All transitions below require ena=1. With ena=0, state, counters and pipe hold, and mac_en/acc_clr/acc_en/res_strb/blk_done are 0.
- IDLE:
  - dstrb=1 or pending=1 -> ISSUE.
  - Same edge: tap_cnt=0, pending cleared, acc_clr=1 for exactly that cycle (registered, asserted in the first ISSUE cycle).
- ISSUE:
  - mac_en=1, tap_sel=tap_cnt, tap_cnt++.
  - When tap_cnt==TAPS-1 -> DRAIN.
  - Exactly TAPS consecutive mac_en cycles while ena=1.
- acc_en:
  - mac_en delayed by MULT_LAT enabled cycles through a shift pipe.
  - The pipe advances only when ena=1.
  - Total acc_en pulses per row = TAPS.
- DRAIN:
  - Wait until the pipe is empty (last acc_en issued), then -> DONE.
  - Length = MULT_LAT enabled cycles after the last mac_en.
- DONE:
  - res_strb=1 for one cycle with row_idx = current row.
  - blk_done=1 if row_idx==ROWS-1.
  - Next cycle: row_idx++ (wraps ROWS-1 -> 0).
  - If pending or dstrb -> ISSUE (back-to-back, acc_clr asserted again); else -> IDLE.
- Latency:
  - dstrb to first mac_en = 1 cycle.
  - dstrb to res_strb = 1 + TAPS + MULT_LAT cycles (enabled cycles).
- Request queue:
  - dstrb while busy (not in the DONE-restart cycle) sets pending.
  - dstrb while pending=1 sets overrun; the extra request is dropped.
  - overrun clears only on reset.
- Simultaneous dstrb and DONE: treated as the immediate restart, not as pending.
- acc_clr and the first acc_en of the same row never coincide for MULT_LAT>=1.
- busy is combinational from state. All other outputs are registered.

Test Plan:
- Single row (TAPS=8, MULT_LAT=2, ena=1):
  - dstrb at cycle 0 -> acc_clr at cycle 1; mac_en cycles 1-8 with tap_sel 0..7; acc_en cycles 3-10; res_strb at cycle 11 with row_idx=0; busy 0 at cycle 12.
- Back-to-back:
  - dstrb at cycle 0 and cycle 4 -> pending set.
  - Second row's acc_clr at cycle 12, res_strb at cycle 22 with row_idx=1; overrun=0.
- Overrun: dstrb at cycles 0, 3, 5 -> overrun=1 from cycle 6; only 2 res_strb pulses.
- Block wrap: 8 spaced dstrb -> row_idx 0..7 on res_strb; blk_done only on the 8th; next row reports row_idx=0.
- Stall: ena=0 for cycles 4-6 during ISSUE -> no mac_en/acc_en in 4-6, tap_sel frozen, res_strb at cycle 14, still exactly 8 acc_en.
- Reset mid-row: rst low at cycle 5 -> all outputs 0 immediately; after release, a new dstrb yields the full 11-cycle sequence with row_idx=0.

Source files
------------

// File: rtl/dct_mac_if.sv
// Control bundle between the DCT MAC sequencer and the row buffer / ROM / macu datapath.
interface dct_mac_if #(
  parameter int TAPS = 8,
  parameter int ROWS = 8
);
  localparam int TW = $clog2(TAPS);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic          ena;
  logic          dstrb;
  logic [TW-1:0] tap_sel;
  logic          mac_en;
  logic          acc_clr;
  logic          acc_en;
  logic          res_strb;
  logic [RW-1:0] row_idx;
  logic          blk_done;
  logic          busy;
  logic          overrun;

  modport master (
    input  ena, dstrb,
    output tap_sel, mac_en, acc_clr, acc_en, res_strb, row_idx, blk_done, busy, overrun
  );
  modport slave (
    output ena, dstrb,
    input  tap_sel, mac_en, acc_clr, acc_en, res_strb, row_idx, blk_done, busy, overrun
  );
endinterface

// File: rtl/dct_mac_sequencer.sv
// Per-row MAC sequencer: TAPS issue cycles, MULT_LAT drain cycles, one result strobe.
// Tracks row index within a block and queues a single pending start request.
module dct_mac_sequencer #(
  parameter int TAPS     = 8,
  parameter int MULT_LAT = 2,
  parameter int ROWS     = 8
) (
  input  logic        clk,
  input  logic        rst,
  dct_mac_if.master   bus
);
  localparam int TW = $clog2(TAPS);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int DW = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]          state;
  logic [TW-1:0]       tap_cnt;
  logic [DW-1:0]       drn_cnt;
  logic [MULT_LAT-1:0] pipe;
  logic [RW-1:0]       row;
  logic                pending, ovr;
  logic                mac_q, clr_q, res_q, blk_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      tap_cnt <= '0;
      drn_cnt <= '0;
      pipe    <= '0;
      row     <= '0;
      pending <= 1'b0;
      ovr     <= 1'b0;
      mac_q   <= 1'b0;
      clr_q   <= 1'b0;
      res_q   <= 1'b0;
      blk_q   <= 1'b0;
    end else if (bus.ena) begin
      pipe[0] <= mac_q;
      for (int i = 1; i < MULT_LAT; i++) pipe[i] <= pipe[i-1];
      clr_q <= 1'b0;
      res_q <= 1'b0;
      blk_q <= 1'b0;
      // A request arriving mid-row is queued; a second one is dropped and flagged.
      if (bus.dstrb && (state == ISSUE || state == DRAIN)) begin
        if (pending) ovr <= 1'b1;
        else         pending <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (bus.dstrb || pending) begin
            state   <= ISSUE;
            tap_cnt <= '0;
            pending <= 1'b0;
            clr_q   <= 1'b1;
            mac_q   <= 1'b1;
          end
        end
        ISSUE: begin
          tap_cnt <= tap_cnt + TW'(1);
          if (tap_cnt == TW'(TAPS-1)) begin
            mac_q   <= 1'b0;
            drn_cnt <= '0;
            state   <= DRAIN;
          end
        end
        DRAIN: begin
          if (drn_cnt == DW'(MULT_LAT-1)) begin
            state <= DONE;
            res_q <= 1'b1;
            blk_q <= (row == RW'(ROWS-1));
          end else begin
            drn_cnt <= drn_cnt + DW'(1);
          end
        end
        default: begin
          row <= row + RW'(1);
          if (bus.dstrb || pending) begin
            state   <= ISSUE;
            tap_cnt <= '0;
            clr_q   <= 1'b1;
            mac_q   <= 1'b1;
            // Restart consumes the queued request; a coincident new strobe stays queued.
            pending <= pending & bus.dstrb;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

  assign bus.tap_sel  = tap_cnt;
  assign bus.mac_en   = mac_q & bus.ena;
  assign bus.acc_clr  = clr_q & bus.ena;
  assign bus.acc_en   = pipe[MULT_LAT-1] & bus.ena;
  assign bus.res_strb = res_q & bus.ena;
  assign bus.blk_done = blk_q & bus.ena;
  assign bus.row_idx  = row;
  assign bus.busy     = (state != IDLE);
  assign bus.overrun  = ovr;
endmodule

// File: tb/tb_dct_mac_sequencer.sv
// Directed bench for dct_mac_sequencer with a result scoreboard and a negedge monitor.
module tb_dct_mac_sequencer;
  localparam int TAPS = 8, ML = 2, ROWS = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dct_mac_if #(.TAPS(TAPS), .ROWS(ROWS)) bus ();
  dct_mac_sequencer #(.TAPS(TAPS), .MULT_LAT(ML), .ROWS(ROWS)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  typedef struct { int cyc; int row; int blk; } exp_t;
  exp_t sb[$];
  exp_t e;

  int checks = 0, failures = 0;
  int cyc = 0, t0 = 0, exp_row = 0;
  int mac_cnt = 0, acc_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic at(input int c);
    while (cyc < c) step(1);
  endtask

  // exp_c < 0: request expected to be dropped
  task automatic req(input int exp_c);
    exp_t x;
    if (exp_c >= 0) begin
      x.cyc = exp_c; x.row = exp_row; x.blk = (exp_row == ROWS-1);
      sb.push_back(x);
      exp_row = (exp_row + 1) % ROWS;
    end
    bus.dstrb = 1'b1;
    step(1);
    bus.dstrb = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mac_cnt = 0;
      acc_cnt = 0;
    end else begin
      if (!bus.ena)
        chk("stall_quiet", {bus.mac_en, bus.acc_en, bus.acc_clr, bus.res_strb, bus.blk_done}, 0);
      if (bus.mac_en) begin
        chk("tap_sel", bus.tap_sel, mac_cnt % TAPS);
        mac_cnt++;
      end
      if (bus.acc_en) acc_cnt++;
      if (bus.acc_clr) chk("clr_vs_acc", bus.acc_en, 0);
      if (bus.blk_done) chk("blk_without_res", bus.res_strb, 1);
      if (bus.res_strb) begin
        if (sb.size() == 0) begin
          chk("unexpected_res", sb.size(), 1);
        end else begin
          e = sb.pop_front();
          chk("res_cycle", cyc, e.cyc);
          chk("row_idx", bus.row_idx, e.row);
          chk("blk_done", bus.blk_done, e.blk);
          chk("acc_en_count", acc_cnt, TAPS);
          chk("mac_en_count", mac_cnt, TAPS);
        end
        mac_cnt = 0;
        acc_cnt = 0;
      end
    end
  end

  initial begin
    int budget;
    bus.ena = 1'b1;
    bus.dstrb = 1'b0;
    step(2);
    @(negedge clk);
    chk("rst_outs", {bus.tap_sel, bus.mac_en, bus.acc_clr, bus.acc_en, bus.res_strb,
                     bus.row_idx, bus.blk_done, bus.busy, bus.overrun}, 0);
    step(1);
    rst = 1'b1;
    step(2);

    // single row
    t0 = cyc; req(t0 + 11);
    at(t0 + 1); @(negedge clk);
    chk("t1_acc_clr", bus.acc_clr, 1);
    chk("t1_mac_en", bus.mac_en, 1);
    chk("t1_busy", bus.busy, 1);
    at(t0 + 12); @(negedge clk);
    chk("t1_idle", bus.busy, 0);
    chk("t1_row_next", bus.row_idx, 1);
    at(t0 + 14);

    // back-to-back via pending
    t0 = cyc; req(t0 + 11);
    at(t0 + 4); req(t0 + 22);
    at(t0 + 12); @(negedge clk);
    chk("t2_acc_clr", bus.acc_clr, 1);
    at(t0 + 23); @(negedge clk);
    chk("t2_overrun", bus.overrun, 0);
    chk("t2_idle", bus.busy, 0);
    at(t0 + 25);

    // overrun: third request dropped
    t0 = cyc; req(t0 + 11);
    at(t0 + 3); req(t0 + 22);
    at(t0 + 5); @(negedge clk);
    chk("t3_no_ovr_yet", bus.overrun, 0);
    at(t0 + 5); req(-1);
    @(negedge clk);
    chk("t3_overrun", bus.overrun, 1);
    at(t0 + 30);
    chk("t3_overrun_sticky", bus.overrun, 1);

    // block wrap: rows 5,6,7,0..4, blk_done on row 7
    for (int k = 0; k < 8; k++) begin
      t0 = cyc; req(t0 + 11);
      at(t0 + 14);
    end

    // stall for three cycles during ISSUE
    t0 = cyc; req(t0 + 14);
    at(t0 + 4); bus.ena = 1'b0;
    @(negedge clk);
    chk("t5_tap_frozen_a", bus.tap_sel, 3);
    at(t0 + 6); @(negedge clk);
    chk("t5_tap_frozen_b", bus.tap_sel, 3);
    chk("t5_busy_held", bus.busy, 1);
    at(t0 + 7); bus.ena = 1'b1;
    at(t0 + 16);

    // reset mid-row
    t0 = cyc; req(t0 + 11);
    at(t0 + 5);
    rst = 1'b0;
    sb.delete();
    exp_row = 0;
    @(negedge clk);
    chk("t6_rst_outs", {bus.tap_sel, bus.mac_en, bus.acc_clr, bus.acc_en, bus.res_strb,
                        bus.row_idx, bus.blk_done, bus.busy, bus.overrun}, 0);
    step(2);
    rst = 1'b1;
    step(2);
    t0 = cyc; req(t0 + 11);
    at(t0 + 1); @(negedge clk);
    chk("t6_acc_clr", bus.acc_clr, 1);
    at(t0 + 14);

    budget = 100;
    while (sb.size() > 0 && budget > 0) begin step(1); budget--; end
    chk("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
